pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazards:
  - load-use data hazards;
  - taken branches/jumps resolved in EX;
  - multi-cycle data-memory accesses sitting in MEM.
- Keeps a registered record of the last action and, optionally, performance counters.

Parameters:
- MEM_WAIT, 2: extra cycles a load/store occupies MEM. 0 means single-cycle memory. Legal range 0..15.
- REG_AW, 5: register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- ID_rs  in  REG_AW  source register 1 of the instruction in ID
- ID_rt  in  REG_AW  source register 2 of the instruction in ID
- EX_MemRead  in  1  instruction in EX is a load
- EX_WriteReg  in  REG_AW  destination register of the instruction in EX
- EX_BranchTaken  in  1  branch/jump in EX resolved taken this cycle
- MEM_MemAccess  in  1  instruction in MEM is a load or store
- PC_en  out  1  PC load enable
- IFID_en  out  1  IF/ID register enable
- IFID_flush  out  1  IF/ID clear to NOP
- IDEX_en  out  1  ID/EX register enable
- IDEX_flush  out  1  ID/EX clear to bubble
- EXMEM_en  out  1  EX/MEM register enable
- MEMWB_bubble  out  1  MEM/WB captures a bubble (RegWrite=0)
- hz_state  out  2  registered action of the previous cycle: 0 RUN, 1 LU_STALL, 2 MEM_WAIT, 3 FLUSH
- wait_cnt  out  4  current MEM wait counter
- stall_cycles  out  32  stall cycle count (see Optional Feature)
- flush_count  out  32  flush event count (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - wait_cnt=0, hz_state=0, counters=0.
  - While reset is asserted, outputs are forced to freeze: all enables 0, both flushes 0, MEMWB_bubble=1.
- Decision logic: outputs are combinational from the inputs and wait_cnt. Priority: MEM hold > branch flush > load-use stall > RUN.
- mem_hold = MEM_MemAccess && (wait_cnt != MEM_WAIT).
  - While mem_hold: PC_en, IFID_en, IDEX_en and EXMEM_en are 0; flushes are 0; MEMWB_bubble=1; wait_cnt increments.
  - When MEM_MemAccess=1 and wait_cnt==MEM_WAIT: no hold and wait_cnt returns to 0. The access therefore occupies MEM for exactly MEM_WAIT+1 cycles.
  - When MEM_MemAccess=0, wait_cnt is forced to 0.
  - MEM_WAIT=0: mem_hold is never asserted.
- Branch flush (EX_BranchTaken and no mem_hold):
  - PC_en=1 (PC loads the target), IFID_flush=1, IDEX_flush=1.
  - All other enables are 1; MEMWB_bubble=0.
  - Lasts one cycle.
- Load-use stall (EX_MemRead && EX_WriteReg!=0 && (EX_WriteReg==ID_rs || EX_WriteReg==ID_rt), no hold, no branch):
  - PC_en=0, IFID_en=0, IDEX_flush=1.
  - IDEX_en=1, EXMEM_en=1, MEMWB_bubble=0.
  - Lasts one cycle; the condition clears naturally when the load advances.
- RUN: all enables 1, flushes 0, MEMWB_bubble=0.
- hz_state register: on each clock edge, captures the action (3 FLUSH, 2 MEM_WAIT, 1 LU_STALL, 0 RUN) taken during that cycle.
- A branch in EX during mem_hold is held in EX, not lost. The flush fires in the first cycle the hold releases.
- Reset asserted mid-wait aborts the wait immediately.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on each cycle with mem_hold or a load-use stall.
  - flush_count increments on each branch-flush cycle.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: ports remain present, driven constant 0, and no counter flops are built.

Test Plan:
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID_rs=8 -> PC_en=0, IFID_en=0, IDEX_flush=1, EXMEM_en=1 for one cycle; next cycle hz_state=1; stall_cycles=1.
- Zero register: EX_MemRead=1, EX_WriteReg=0, ID_rt=0 -> no stall, all enables 1, hz_state stays 0.
- MEM_WAIT=2, MEM_MemAccess held high -> hold for 2 cycles (wait_cnt 0,1), advance on the 3rd (wait_cnt=2, then 0); MEMWB_bubble=1 only in the 2 hold cycles.
- Branch: EX_BranchTaken=1 alone -> PC_en=1, IFID_flush=1, IDEX_flush=1 for one cycle; hz_state=3 next; flush_count=1.
- Branch during hold: EX_BranchTaken=1 with MEM_MemAccess=1, wait_cnt=0, MEM_WAIT=2 -> no flush for 2 cycles; flush asserted in the release cycle only.
- Reset mid-wait: reset driven 0 while wait_cnt=1 -> wait_cnt=0, hz_state=0, counters 0 and all enables 0 immediately, without a clock edge; normal RUN resumes after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. It drives the
// enable, flush and bubble controls of the PC and the four pipeline registers.
// It resolves multi-cycle data-memory accesses in MEM, taken branches/jumps
// resolved in EX, and load-use data hazards, in that priority order.
//
// Parameters
//   MEM_WAIT  extra cycles a load/store occupies MEM (0 = single cycle, 0..15)
//   REG_AW    register-address width
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous active-low reset (asserted when 0)
//   ID_rs, ID_rt    source registers of the instruction in ID
//   EX_MemRead      instruction in EX is a load
//   EX_WriteReg     destination register of the instruction in EX
//   EX_BranchTaken  branch/jump in EX resolved taken this cycle
//   MEM_MemAccess   instruction in MEM is a load or store
//   PC_en, IFID_en, IDEX_en, EXMEM_en   register load enables
//   IFID_flush, IDEX_flush              clear to NOP / bubble
//   MEMWB_bubble    MEM/WB captures a bubble (RegWrite=0)
//   hz_state        action taken in the previous cycle
//                   (0 RUN, 1 LU_STALL, 2 MEM_WAIT, 3 FLUSH)
//   wait_cnt        current MEM wait counter
//   stall_cycles    stall cycle count (saturating)
//   flush_count     branch flush count (saturating)
//
// Optional feature
//   HAZ_PERF_CNT_EN  when defined, builds the two saturating performance
//                    counters; when undefined, both counter ports read 0 and
//                    no counter flops exist.

module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 2,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] EX_WriteReg,
  input  logic              EX_BranchTaken,
  input  logic              MEM_MemAccess,
  output logic              PC_en,
  output logic              IFID_en,
  output logic              IFID_flush,
  output logic              IDEX_en,
  output logic              IDEX_flush,
  output logic              EXMEM_en,
  output logic              MEMWB_bubble,
  output logic [1:0]        hz_state,
  output logic [3:0]        wait_cnt,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
);

  typedef enum logic [1:0] {
    ACT_RUN      = 2'd0,
    ACT_LU_STALL = 2'd1,
    ACT_MEM_WAIT = 2'd2,
    ACT_FLUSH    = 2'd3
  } hz_act_e;

  // Wait count at which the memory access is allowed to leave MEM.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  logic [3:0] wait_q;
  logic [3:0] wait_d;
  hz_act_e    state_q;
  hz_act_e    act;
  logic       mem_hold;
  logic       lu_hazard;

  // With MEM_WAIT=0 the counter never leaves 0, so the hold never asserts.
  assign mem_hold = MEM_MemAccess && (wait_q != WAIT_LAST);

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu_hazard = EX_MemRead && (EX_WriteReg != '0) &&
                     ((EX_WriteReg == ID_rs) || (EX_WriteReg == ID_rt));

  // Priority decision: reset freeze, then MEM hold, then branch flush, then
  // load-use stall, otherwise RUN. A branch in EX during a hold stays in EX
  // because ID/EX and EX/MEM are frozen, so its flush fires on release.
  always_comb begin
    act          = ACT_RUN;
    wait_d       = '0;
    PC_en        = 1'b1;
    IFID_en      = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_en      = 1'b1;
    IDEX_flush   = 1'b0;
    EXMEM_en     = 1'b1;
    MEMWB_bubble = 1'b0;
    if (!reset) begin
      PC_en        = 1'b0;
      IFID_en      = 1'b0;
      IDEX_en      = 1'b0;
      EXMEM_en     = 1'b0;
      MEMWB_bubble = 1'b1;
    end else if (mem_hold) begin
      act          = ACT_MEM_WAIT;
      wait_d       = wait_q + 4'd1;
      PC_en        = 1'b0;
      IFID_en      = 1'b0;
      IDEX_en      = 1'b0;
      EXMEM_en     = 1'b0;
      MEMWB_bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      act        = ACT_FLUSH;
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (lu_hazard) begin
      act        = ACT_LU_STALL;
      PC_en      = 1'b0;
      IFID_en    = 1'b0;
      IDEX_flush = 1'b1;
    end
  end

  // Wait counter and record of the action taken in the cycle just ended.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q  <= '0;
      state_q <= ACT_RUN;
    end else begin
      wait_q  <= wait_d;
      state_q <= act;
    end
  end

  assign wait_cnt = wait_q;
  assign hz_state = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Saturating counters: MEM holds and load-use stalls both count as stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (((act == ACT_MEM_WAIT) || (act == ACT_LU_STALL)) && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if ((act == ACT_FLUSH) && (flush_q != '1))
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl with MEM_WAIT=2. Single-cycle
// vectors come from a table; multi-cycle corners (MEM hold, branch during
// hold, early access drop, reset mid-wait) are hand-written sequences.
// Expected values are queued when stimulus is driven and popped when the
// outputs are sampled on the falling edge.

module tb_pipe_hazard_ctrl;

  localparam int AW = 5;

  // Control vector order: {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_bubble}
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_FLUSH  = 7'b1111110;
  localparam logic [6:0] C_HOLD   = 7'b0000001;
  localparam logic [6:0] C_FREEZE = 7'b0000001;

  localparam logic [1:0] A_RUN  = 2'd0;
  localparam logic [1:0] A_LU   = 2'd1;
  localparam logic [1:0] A_WAIT = 2'd2;
  localparam logic [1:0] A_FL   = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ID_rs;
  logic [AW-1:0] ID_rt;
  logic          EX_MemRead;
  logic [AW-1:0] EX_WriteReg;
  logic          EX_BranchTaken;
  logic          MEM_MemAccess;
  logic          PC_en;
  logic          IFID_en;
  logic          IFID_flush;
  logic          IDEX_en;
  logic          IDEX_flush;
  logic          EXMEM_en;
  logic          MEMWB_bubble;
  logic [1:0]    hz_state;
  logic [3:0]    wait_cnt;
  logic [31:0]   stall_cycles;
  logic [31:0]   flush_count;

  pipe_hazard_ctrl #(.MEM_WAIT(2), .REG_AW(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .EX_MemRead     (EX_MemRead),
    .EX_WriteReg    (EX_WriteReg),
    .EX_BranchTaken (EX_BranchTaken),
    .MEM_MemAccess  (MEM_MemAccess),
    .PC_en          (PC_en),
    .IFID_en        (IFID_en),
    .IFID_flush     (IFID_flush),
    .IDEX_en        (IDEX_en),
    .IDEX_flush     (IDEX_flush),
    .EXMEM_en       (EXMEM_en),
    .MEMWB_bubble   (MEMWB_bubble),
    .hz_state       (hz_state),
    .wait_cnt       (wait_cnt),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          mr;
    logic [AW-1:0] wr;
    logic          br;
    logic          ma;
    logic [6:0]    ctl;
    logic [1:0]    act;
  } vec_t;

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [3:0]  wt;
    logic [1:0]  hz;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[11];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [1:0]  last_act     = A_RUN;
  logic [31:0] cnt_stall    = 0;
  logic [31:0] cnt_flush    = 0;

  task automatic checkField(input string name, input string field,
                            input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, got, want);
    end
  endtask

  // Queue the expectation for the current cycle, using the bench's record of
  // the previous action and counter totals for the registered outputs.
  task automatic pushExpected(input string name, input logic [6:0] ctl,
                              input logic [3:0] wt);
    exp_t e;
    e.name = name;
    e.ctl  = ctl;
    e.wt   = wt;
    e.hz   = last_act;
`ifdef HAZ_PERF_CNT_EN
    e.st   = cnt_stall;
    e.fl   = cnt_flush;
`else
    e.st   = 32'd0;
    e.fl   = 32'd0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input string name,
                               input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                               input logic mr, input logic [AW-1:0] wr,
                               input logic br, input logic ma,
                               input logic [6:0] ctl, input logic [1:0] act,
                               input logic [3:0] wt);
    @(posedge clk);
    #1;
    ID_rs          = rs;
    ID_rt          = rt;
    EX_MemRead     = mr;
    EX_WriteReg    = wr;
    EX_BranchTaken = br;
    MEM_MemAccess  = ma;
    pushExpected(name, ctl, wt);
    last_act = act;
    if (act == A_LU || act == A_WAIT) cnt_stall++;
    if (act == A_FL) cnt_flush++;
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [6:0] got_ctl;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb_q.pop_front();
      got_ctl = {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_bubble};
      checkField(e.name, "ctl",          32'(got_ctl),  32'(e.ctl));
      checkField(e.name, "wait_cnt",     32'(wait_cnt), 32'(e.wt));
      checkField(e.name, "hz_state",     32'(hz_state), 32'(e.hz));
      checkField(e.name, "stall_cycles", stall_cycles,  e.st);
      checkField(e.name, "flush_count",  flush_count,   e.fl);
    end
  endtask

  task automatic setIdle();
    ID_rs          = '0;
    ID_rt          = '0;
    EX_MemRead     = 1'b0;
    EX_WriteReg    = '0;
    EX_BranchTaken = 1'b0;
    MEM_MemAccess  = 1'b0;
  endtask

  task automatic step(input string name,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic mr, input logic [AW-1:0] wr,
                      input logic br, input logic ma,
                      input logic [6:0] ctl, input logic [1:0] act,
                      input logic [3:0] wt);
    applyStimulus(name, rs, rt, mr, wr, br, ma, ctl, act, wt);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //          name           rs  rt  mr wr  br ma ctl      act
    vecs[0]  = '{"run",        1,  2,  0, 0,  0, 0, C_RUN,   A_RUN};
    vecs[1]  = '{"lu_rs",      8,  3,  1, 8,  0, 0, C_LU,    A_LU};
    vecs[2]  = '{"run2",       4,  5,  0, 8,  0, 0, C_RUN,   A_RUN};
    vecs[3]  = '{"lu_rt",      2,  9,  1, 9,  0, 0, C_LU,    A_LU};
    vecs[4]  = '{"zero_reg",   0,  0,  1, 0,  0, 0, C_RUN,   A_RUN};
    vecs[5]  = '{"load_nomat", 3,  4,  1, 7,  0, 0, C_RUN,   A_RUN};
    vecs[6]  = '{"nonload",    8,  8,  0, 8,  0, 0, C_RUN,   A_RUN};
    vecs[7]  = '{"branch",     1,  2,  0, 0,  1, 0, C_FLUSH, A_FL};
    vecs[8]  = '{"run3",       1,  2,  0, 0,  0, 0, C_RUN,   A_RUN};
    vecs[9]  = '{"br_over_lu", 6,  1,  1, 6,  1, 0, C_FLUSH, A_FL};
    vecs[10] = '{"run4",       1,  2,  0, 0,  0, 0, C_RUN,   A_RUN};

    // Reset state: frozen controls, cleared registers.
    reset = 1'b0;
    setIdle();
    #2;
    pushExpected("reset", C_FREEZE, 4'd0);
    checkOutput();
    #8 reset = 1'b1;

    for (int i = 0; i < 11; i++)
      step(vecs[i].name, vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].wr,
           vecs[i].br, vecs[i].ma, vecs[i].ctl, vecs[i].act, 4'd0);

    // MEM access held high: two hold cycles, released on the third.
    step("hold0",   0, 0, 0, 0, 0, 1, C_HOLD, A_WAIT, 4'd0);
    step("hold1",   0, 0, 0, 0, 0, 1, C_HOLD, A_WAIT, 4'd1);
    step("release", 0, 0, 0, 0, 0, 1, C_RUN,  A_RUN,  4'd2);
    step("after",   0, 0, 0, 0, 0, 0, C_RUN,  A_RUN,  4'd0);

    // Branch in EX during a hold: flush only in the release cycle.
    step("bh0",     0, 0, 0, 0, 1, 1, C_HOLD,  A_WAIT, 4'd0);
    step("bh1",     0, 0, 0, 0, 1, 1, C_HOLD,  A_WAIT, 4'd1);
    step("bh_rel",  0, 0, 0, 0, 1, 1, C_FLUSH, A_FL,   4'd2);
    step("bh_after",0, 0, 0, 0, 0, 0, C_RUN,   A_RUN,  4'd0);

    // Hold beats load-use; access drops early and the counter is forced back.
    step("lh0",     8, 0, 1, 8, 0, 1, C_HOLD, A_WAIT, 4'd0);
    step("lh_drop", 8, 0, 1, 8, 0, 0, C_LU,   A_LU,   4'd1);
    step("lh_after",0, 0, 0, 0, 0, 0, C_RUN,  A_RUN,  4'd0);

    // Reset asserted mid-wait takes effect without a clock edge.
    step("rw0",     0, 0, 0, 0, 0, 1, C_HOLD, A_WAIT, 4'd0);
    step("rw1",     0, 0, 0, 0, 0, 1, C_HOLD, A_WAIT, 4'd1);
    #2 reset = 1'b0;
    last_act  = A_RUN;
    cnt_stall = 0;
    cnt_flush = 0;
    #1;
    pushExpected("rst_async", C_FREEZE, 4'd0);
    checkOutput();
    @(posedge clk);
    #1;
    pushExpected("rst_held", C_FREEZE, 4'd0);
    checkOutput();
    setIdle();
    #2 reset = 1'b1;
    step("rst_run", 0, 0, 0, 0, 0, 0, C_RUN, A_RUN, 4'd0);
    step("rst_lu",  0, 5, 1, 5, 0, 0, C_LU,  A_LU,  4'd0);
    step("rst_end", 0, 0, 0, 0, 0, 0, C_RUN, A_RUN, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
